adder_operand_sequencer: RTL
============================

# adder_operand_sequencer

Sequential front/back stage for `nBitAdder_module`. It captures two N-bit operands from board switches on successive `load` presses and drives them to the adder. It then registers the adder's sum and flags, and holds them for display together with a state code and an operation counter. It replaces hand-driven operand stimulus so the adder can be exercised on the FPGA board.

## Interface
- `N`, default 4: operand/result width.
- `clk`  in  1: system clock, rising-edge active.
- `rst`  in  1: asynchronous, active-high reset.
- `sw`  in  N: operand value from switches; sampled only on a load edge.
- `load`  in  1: already-debounced, synchronous level. The block performs its own rising-edge detection.
- `clear`  in  1: synchronous clear. It has priority over `load`.
- `r_in`  in  N: sum from the adder (combinational, driven by `a`/`b`).
- `f_in`  in  4: flags from the adder, `{N,Z,C,V}` = `f_in[3:0]`.
- `a`  out  N: operand A to the adder, registered.
- `b`  out  N: operand B to the adder, registered.
- `result`  out  N: captured sum, registered.
- `flags`  out  4: captured flags, registered, same bit order as `f_in`.
- `state`  out  2: current FSM state code, for LEDs.
- `done`  out  1: one-cycle pulse when result and flags are captured.
- `count`  out  8: number of completed captures; wraps from 255 to 0.

## Operation
- Edge detect:
  - `load_q` registers `load`; `load_q` resets to 1.
  - `load_edge = load & ~load_q`.
  - Holding `load` high yields exactly one edge. A `load` level already high at reset release yields no edge.
- FSM states: `WAIT_A`=00, `WAIT_B`=01, `EXEC`=10, `SHOW`=11.
  - `WAIT_A`: on `load_edge`, `a <= sw` and go to `WAIT_B`.
  - `WAIT_B`: on `load_edge`, `b <= sw` and go to `EXEC`.
  - `EXEC`: unconditional, lasts one cycle. `result <= r_in`, `flags <= f_in`, `count <= count+1`, `done <= 1`, then go to `SHOW`.
  - `SHOW`: `result`/`flags` hold. On `load_edge`, `a <= sw` and go to `WAIT_B`; this starts the next operation, and `result` keeps its old value until the next `EXEC`.
- `load_edge` in `EXEC` is ignored: not captured and not queued.
- `clear` (any state, cycle sampled high):
  - next state `WAIT_A`.
  - `a`, `b`, `result`, `flags` are set to 0; `done` is 0.
  - `count` is retained.
  - A `load_edge` in the same cycle is discarded.
- `a`/`b` change only on their capture edges and are otherwise stable. The adder sees constant operands throughout `EXEC`.
- No arithmetic is performed here except the `count` increment, which is 8-bit modulo 256.
- `state` output equals the state register.

## Timing
- Reset (async, immediate on `rst`=1): `state`=00, `a`=0, `b`=0, `result`=0, `flags`=0, `done`=0, `count`=0, `load_q`=1.
- `load` rising at cycle t (first cycle sampled 1): the capture register updates at the clock edge ending cycle t.
- Latency for the B edge in cycle t:
  - cycle t+1: state=`EXEC`.
  - end of t+1: `result`/`flags`/`count` update.
  - cycle t+2: `done`=1 and state=`SHOW`.
  - cycle t+3: `done`=0.
- `result`/`flags` sample `r_in`/`f_in` during `EXEC`, one full cycle after `b` is registered, so the adder has one cycle of combinational settle time.
- `rst` asserted mid-operation aborts immediately. After release, operation restarts in `WAIT_A` and `count`=0.
- Minimum operation period: 4 cycles.
  - A and B need separate edges, so `load` must go low between them.

## Test plan
- Reset with `load`=1 held through release → no capture, state=00, all outputs 0. Drop then raise `load` with `sw`=1001 → `a`=1001, state=01.
- Full sequence with `nBitAdder_module` attached, `sw`=1001 then 0101 → two cycles after the B edge: `done`=1 for exactly one cycle, `result`=1110, `flags`=1000, `count`=1, state=11.
- From `SHOW`, load 1111 then 0001 → `result`=0000, `flags`=0110.
  - Between the A load and `EXEC`, `result` must still read 1110.
- `load` held high for 10 cycles in `WAIT_A` → exactly one capture. `load` edge during `EXEC` → ignored, and `a` is unchanged.
- `clear` in `WAIT_B` with simultaneous `load` edge → state=00, `a`=`b`=`result`=`flags`=0, `count` retained, no capture.
- 256 back-to-back operations (1000+0100 repeated) → `count` wraps to 0. Async `rst` pulse mid-`EXEC` → all outputs 0 immediately, and no `done` pulse.

Source files
------------

// File: rtl/adder_operand_sequencer_if.sv
// Switch/adder-side signal bundle for adder_operand_sequencer.
// master = board/adder side, slave = the sequencer.
interface adder_operand_sequencer_if #(parameter int N = 4);
  logic [N-1:0] sw;
  logic         load;
  logic         clear;
  logic [N-1:0] r_in;
  logic [3:0]   f_in;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] result;
  logic [3:0]   flags;
  logic [1:0]   state;
  logic         done;
  logic [7:0]   count;

  modport master (output sw, load, clear, r_in, f_in,
                  input  a, b, result, flags, state, done, count);
  modport slave  (input  sw, load, clear, r_in, f_in,
                  output a, b, result, flags, state, done, count);
endinterface

// File: rtl/adder_operand_sequencer.sv
// Captures two operands on successive load presses, feeds them to an external
// adder, then registers its sum/flags and holds them for display.
module adder_operand_sequencer #(
  parameter int N = 4
) (
  input logic                    clk,
  input logic                    rst,
  adder_operand_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    EXEC   = 2'b10,
    SHOW   = 2'b11
  } state_t;

  state_t       cur, nxt;
  logic         load_q, load_edge;
  logic         cap_a, cap_b, cap_r;
  logic [N-1:0] a_q, b_q, result_q;
  logic [3:0]   flags_q;
  logic         done_q;
  logic [7:0]   count_q;

  // load_q resets high so a level already asserted at reset release is not an edge
  always_ff @(posedge clk or posedge rst)
    if (rst) load_q <= 1'b1;
    else     load_q <= bus.load;

  assign load_edge = bus.load & ~load_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) cur <= WAIT_A;
    else     cur <= nxt;

  always_comb begin
    nxt = cur;
    if (bus.clear) nxt = WAIT_A;
    else begin
      case (cur)
        WAIT_A: if (load_edge) nxt = WAIT_B;
        WAIT_B: if (load_edge) nxt = EXEC;
        EXEC:                  nxt = SHOW;
        SHOW:   if (load_edge) nxt = WAIT_B;
        default:               nxt = WAIT_A;
      endcase
    end
  end

  // EXEC ignores load edges outright; clear suppresses every capture
  always_comb begin
    cap_a = 1'b0;
    cap_b = 1'b0;
    cap_r = 1'b0;
    if (!bus.clear) begin
      cap_a = load_edge && (cur == WAIT_A || cur == SHOW);
      cap_b = load_edge && (cur == WAIT_B);
      cap_r = (cur == EXEC);
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      done_q <= cap_r;
      if (bus.clear) begin
        a_q      <= '0;
        b_q      <= '0;
        result_q <= '0;
        flags_q  <= '0;
      end
      if (cap_a) a_q <= bus.sw;
      if (cap_b) b_q <= bus.sw;
      if (cap_r) begin
        result_q <= bus.r_in;
        flags_q  <= bus.f_in;
        count_q  <= count_q + 8'd1;
      end
    end

  assign bus.a      = a_q;
  assign bus.b      = b_q;
  assign bus.result = result_q;
  assign bus.flags  = flags_q;
  assign bus.done   = done_q;
  assign bus.count  = count_q;
  assign bus.state  = cur;

endmodule
